pixel_fetch: RTL



---
 rtl/sobel_pkg.sv | 14 +
 rtl/pixel_addr_gen.sv | 88 ++++++++
 rtl/pixel_fetch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pixel-fetch path.
package sobel_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_N     = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        SHIFT
    } fetch_state_t;

endpackage

// File: rtl/pixel_addr_gen.sv
// Raster traversal for pixel_fetch: row-base/column/k counters, read address,
// and the column/row/image boundary flags. Address math uses adds only.
module pixel_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        k,
    output logic              col_last,
    output logic              row_first,
    output logic              win_fill,
    output logic              img_end
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    logic [XW-1:0]     x;
    logic [YW-1:0]     yc;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_base;
    logic [ADDR_W-1:0] rd_addr;
    logic              row_end;

    // col_base tracks the top pixel of the column being filled; k selects a row below it
    always_comb begin
        rd_addr = col_base;
        case (k)
            2'd0:    rd_addr = col_base;
            2'd1:    rd_addr = col_base + STRIDE;
            default: rd_addr = col_base + STRIDE + STRIDE;
        endcase
    end

    assign col_last  = (k == 2'd2);
    assign row_end   = (x == XW'(IMG_W - 1));
    assign row_first = (k == 2'd0) && (x == '0);
    assign win_fill  = col_last && (x == XW'(2));
    assign img_end   = col_last && row_end && (yc == YW'(IMG_H - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            k        <= '0;
            x        <= '0;
            yc       <= YW'(1);
            row_base <= BASE;
            col_base <= BASE;
        end else begin
            if (issue)
                mem_addr <= rd_addr;
            if (clear) begin
                k        <= '0;
                x        <= '0;
                yc       <= YW'(1);
                row_base <= BASE;
                col_base <= BASE;
            end else if (step && !img_end) begin
                if (!col_last) begin
                    k <= k + 2'd1;
                end else begin
                    k <= '0;
                    if (row_end) begin
                        x        <= '0;
                        yc       <= yc + YW'(1);
                        row_base <= row_base + STRIDE;
                        col_base <= row_base + STRIDE;
                    end else begin
                        x        <= x + XW'(1);
                        col_base <= col_base + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pixel_fetch.sv
// Pixel-read responder: fetches one pixel per start_read into a 3x3 window.
// Optional WAIT watchdog enabled by defining PIXEL_FETCH_TIMEOUT_EN.
module pixel_fetch
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_param,
    input  logic                   start_read,
    output logic                   read_done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [PIX_W-1:0]       mem_rdata,
    input  logic                   mem_rvalid,
    output logic [WIN_N*PIX_W-1:0] window,
    output logic                   window_valid,
    output logic                   all_done,
    output logic                   err
);

    fetch_state_t     state;
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] stage0;
    logic [PIX_W-1:0] stage1;
    logic [PIX_W-1:0] pix;
    logic [1:0]       k;
    logic             col_last;
    logic             row_first;
    logic             win_fill;
    logic             img_end;
    logic             issue;
    logic             step;
    logic             timed_out;

`ifdef PIXEL_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timed_out = (state == WAIT) && !mem_rvalid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT)
            wait_cnt <= '0;
        else if (!mem_rvalid)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    assign timed_out = 1'b0;
`endif

    assign issue = (state == IDLE) && start_read && !all_done && !load_param && !rst;
    assign step  = (state == WAIT) && (mem_rvalid || timed_out) && !load_param && !rst;
    // A watchdog expiry substitutes a zero pixel so the window keeps moving
    assign pix   = mem_rvalid ? mem_rdata : '0;

    pixel_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_param),
        .issue     (issue),
        .step      (step),
        .mem_addr  (mem_addr),
        .k         (k),
        .col_last  (col_last),
        .row_first (row_first),
        .win_fill  (win_fill),
        .img_end   (img_end)
    );

    // Control: FSM, strobes and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_rd_en    <= 1'b0;
            read_done    <= 1'b0;
            window_valid <= 1'b0;
            all_done     <= 1'b0;
            err          <= 1'b0;
        end else if (load_param) begin
            state        <= IDLE;
            mem_rd_en    <= 1'b0;
            read_done    <= 1'b0;
            window_valid <= 1'b0;
            all_done     <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            read_done <= 1'b0;
            if (start_read && !issue)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= ISSUE;
                        mem_rd_en <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (step) begin
                        state     <= SHIFT;
                        read_done <= 1'b1;
                        if (timed_out)
                            err <= 1'b1;
                        if (win_fill)
                            window_valid <= 1'b1;
                        else if (row_first)
                            window_valid <= 1'b0;
                        if (img_end)
                            all_done <= 1'b1;
                    end
                end
                SHIFT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data: staging rows and the 3x3 window, advanced on each accepted pixel
    always_ff @(posedge clk) begin
        if (step) begin
            if (k == 2'd0)
                stage0 <= pix;
            if (k == 2'd1)
                stage1 <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (step && col_last) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= stage0;
            win[1][2] <= stage1;
            win[2][2] <= pix;
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                window[PIX_W*(3*r+c) +: PIX_W] = win[r][c];
    end

endmodule
